i2s_rx: RTL and testbench

I2S_RX -- requirements
Module: i2s_rx

---
 rtl/i2s_rx_if.sv | 24 ++
 rtl/i2s_rx.sv | 122 ++++++++++++
 tb/tb_i2s_rx.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/i2s_rx_if.sv
// Signal bundle between an I2S codec/FIFO environment and the i2s_rx receiver.
// The receiver uses the slave view; the driving side uses the master view.
interface i2s_rx_if #(
  parameter int unsigned DATA_BITS = 16
);
  logic                   SCLK;
  logic                   LRCLK;
  logic                   DOUT;
  logic                   FIFO_FULL;
  logic                   CLEAR_OVF;
  logic [2*DATA_BITS-1:0] AUDIO_OUT;
  logic                   FIFO_WRITE;
  logic                   OVERFLOW;

  modport master (
    output SCLK, LRCLK, DOUT, FIFO_FULL, CLEAR_OVF,
    input  AUDIO_OUT, FIFO_WRITE, OVERFLOW
  );

  modport slave (
    input  SCLK, LRCLK, DOUT, FIFO_FULL, CLEAR_OVF,
    output AUDIO_OUT, FIFO_WRITE, OVERFLOW
  );
endinterface

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples SCLK/LRCLK/DOUT on MCLK, assembles {left,right}
// sample pairs and writes them to a downstream FIFO with a sticky overflow flag.
module i2s_rx #(
  parameter int unsigned DATA_BITS = 16
) (
  input logic     MCLK,
  input logic     RESET_N,
  i2s_rx_if.slave bus
);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  state_t state, state_next;

  logic [1:0]             sclk_sync, lr_sync, dout_sync;
  logic                   sclk_prev;
  logic                   strobe;
  logic                   smp_lr, smp_dout;
  logic                   lr_prev;
  logic [5:0]             slot, slot_inc;
  logic [DATA_BITS-1:0]   shift_reg, shift_next, left_hold;
  logic [2*DATA_BITS-1:0] audio;
  logic                   fifo_write, overflow;
  logic                   boundary, lr_rise, lr_fall;
  logic                   capture, latch_left, write_try;

  assign boundary = strobe && (smp_lr != lr_prev);
  assign lr_rise  = boundary && smp_lr;
  assign lr_fall  = boundary && !smp_lr;

  // Bits land at fixed MSB-aligned positions, so a short word stays zero-padded.
  always_comb begin
    slot_inc   = (slot == 6'd63) ? slot : slot + 6'd1;
    capture    = strobe && !boundary && (slot_inc <= 6'(DATA_BITS));
    shift_next = shift_reg;
    for (int unsigned i = 0; i < DATA_BITS; i++) begin
      if (capture && (slot_inc == 6'(DATA_BITS - i))) shift_next[i] = smp_dout;
    end
  end

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) state <= SYNC;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    latch_left = 1'b0;
    write_try  = 1'b0;
    unique case (state)
      SYNC:  if (lr_fall) state_next = LEFT;
      LEFT:  if (lr_rise) begin
               latch_left = 1'b1;
               state_next = RIGHT;
             end
      RIGHT: if (lr_fall) begin
               write_try  = 1'b1;
               state_next = LEFT;
             end
      default: state_next = SYNC;
    endcase
  end

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sclk_sync  <= '0;
      lr_sync    <= '0;
      dout_sync  <= '0;
      sclk_prev  <= 1'b0;
      strobe     <= 1'b0;
      smp_lr     <= 1'b0;
      smp_dout   <= 1'b0;
      lr_prev    <= 1'b0;
      slot       <= '0;
      shift_reg  <= '0;
      left_hold  <= '0;
      audio      <= '0;
      fifo_write <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], bus.SCLK};
      lr_sync   <= {lr_sync[0], bus.LRCLK};
      dout_sync <= {dout_sync[0], bus.DOUT};
      sclk_prev <= sclk_sync[1];
      // Strobe and samples are registered together so they stay aligned.
      strobe    <= sclk_sync[1] & ~sclk_prev;
      smp_lr    <= lr_sync[1];
      smp_dout  <= dout_sync[1];

      if (strobe) begin
        lr_prev <= smp_lr;
        if (boundary) begin
          slot      <= '0;
          shift_reg <= '0;
        end else begin
          slot      <= slot_inc;
          shift_reg <= shift_next;
        end
      end

      if (latch_left) left_hold <= shift_reg;

      fifo_write <= 1'b0;
      if (write_try && !bus.FIFO_FULL) begin
        audio      <= {left_hold, shift_reg};
        fifo_write <= 1'b1;
      end

      if (write_try && bus.FIFO_FULL) overflow <= 1'b1;
      else if (bus.CLEAR_OVF)         overflow <= 1'b0;
    end
  end

  assign bus.AUDIO_OUT  = audio;
  assign bus.FIFO_WRITE = fifo_write;
  assign bus.OVERFLOW   = overflow;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx (DATA_BITS = 16): frame capture, latency, reset abort,
// short words, FIFO-full overflow, SCLK stall and randomized SCLK phase/rate.
module tb_i2s_rx;

  localparam int unsigned DB = 16;

  logic mclk;
  logic reset_n;

  i2s_rx_if #(.DATA_BITS(DB)) bus();

  i2s_rx #(.DATA_BITS(DB)) dut (
    .MCLK    (mclk),
    .RESET_N (reset_n),
    .bus     (bus)
  );

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int stray  = 0;
  int half_ns = 20;
  time last_rise = 0;
  time wr_time = 0;
  logic [2*DB-1:0] wq[$];
  logic [2*DB-1:0] exp_q[$];
  logic [2*DB-1:0] prev_audio = '0;

  // Write collector; also flags any AUDIO_OUT change that is not a write.
  always @(negedge mclk) begin
    if (bus.FIFO_WRITE === 1'b1) begin
      wq.push_back(bus.AUDIO_OUT);
      wr_cnt++;
      wr_time = $time - 5;
    end else if (reset_n && (bus.AUDIO_OUT !== prev_audio)) begin
      stray++;
    end
    prev_audio = bus.AUDIO_OUT;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [2*DB-1:0] exp);
    logic [2*DB-1:0] obs;
    obs = (wq.size() > 0) ? wq.pop_front() : 'x;
    chk(tag, 64'(obs), 64'(exp));
  endtask

  // Slot 0 carries the previous word's LSB (driven 1 as junk); slots past DB are 1s.
  function automatic logic word_bit(input logic [DB-1:0] w, input int s);
    if (s == 0) return 1'b1;
    if (s <= int'(DB)) return w[int'(DB) - s];
    return 1'b1;
  endfunction

  task automatic slot_bit(input logic lr, input logic d);
    bus.LRCLK = lr;
    bus.DOUT  = d;
    #(half_ns);
    bus.SCLK  = 1'b1;
    last_rise = $time;
    #(half_ns);
    bus.SCLK  = 1'b0;
  endtask

  task automatic send_word(input logic lr, input logic [DB-1:0] w, input int from, input int upto);
    for (int s = from; s < upto; s++) slot_bit(lr, word_bit(w, s));
  endtask

  // A frame body omits left slot 0; lead() supplies it and ends the previous frame.
  task automatic body(input logic [DB-1:0] l, input logic [DB-1:0] r, input int n);
    send_word(1'b0, l, 1, n);
    send_word(1'b1, r, 0, n);
  endtask

  task automatic lead();
    slot_bit(1'b0, 1'b1);
  endtask

  task automatic settle();
    repeat (10) @(negedge mclk);
  endtask

  int base;
  int lat;
  logic [DB-1:0] rl, rr;

  initial begin
    bus.SCLK = 1'b0; bus.LRCLK = 1'b0; bus.DOUT = 1'b0;
    bus.FIFO_FULL = 1'b0; bus.CLEAR_OVF = 1'b0;
    reset_n = 1'b0;
    repeat (4) @(negedge mclk);
    chk("reset_audio", 64'(bus.AUDIO_OUT), 64'h0);
    chk("reset_write", 64'(bus.FIFO_WRITE), 64'h0);
    chk("reset_ovf",   64'(bus.OVERFLOW), 64'h0);
    reset_n = 1'b1;
    @(negedge mclk);
    #2;

    // Basic 64-SCLK frame with latency measurement.
    slot_bit(1'b1, 1'b1);
    lead();
    base = wr_cnt;
    body(16'hA5C3, 16'h1234, 32);
    lead();
    settle();
    chk("basic_count", 64'(wr_cnt - base), 64'd1);
    pop_chk("basic_data", 32'hA5C31234);
    lat = int'((wr_time - last_rise + 9) / 10);
    chk("basic_latency_4pm1", 64'(lat >= 3 && lat <= 5), 64'd1);

    // Reset mid-right-word, release mid-right-word, then three frames.
    base = wr_cnt;
    send_word(1'b0, 16'h7777, 1, 32);
    send_word(1'b1, 16'h8888, 0, 10);
    reset_n = 1'b0;
    send_word(1'b1, 16'h8888, 10, 20);
    chk("rst_mid_audio", 64'(bus.AUDIO_OUT), 64'h0);
    reset_n = 1'b1;
    send_word(1'b1, 16'h8888, 20, 32);
    lead();
    body(16'h0001, 16'h8000, 32); lead();
    body(16'hFFFF, 16'h0000, 32); lead();
    body(16'h3C5A, 16'hC3A5, 32); lead();
    settle();
    chk("rst_count", 64'(wr_cnt - base), 64'd3);
    pop_chk("rst_f1", 32'h00018000);
    pop_chk("rst_f2", 32'hFFFF0000);
    pop_chk("rst_f3", 32'h3C5AC3A5);

    // Short words: 8 data bits per channel land MSB-aligned, zero-padded.
    base = wr_cnt;
    body(16'hFF00, 16'h5A00, 9);
    lead();
    settle();
    chk("short_count", 64'(wr_cnt - base), 64'd1);
    pop_chk("short_data", 32'hFF005A00);

    // FIFO_FULL during frame 2 of 3.
    base = wr_cnt;
    body(16'h1111, 16'h2222, 32); lead();
    send_word(1'b0, 16'h3333, 1, 32);
    bus.FIFO_FULL = 1'b1;
    send_word(1'b1, 16'h4444, 0, 32);
    lead();
    send_word(1'b0, 16'h5555, 1, 4);
    bus.FIFO_FULL = 1'b0;
    chk("ovf_set", 64'(bus.OVERFLOW), 64'd1);
    chk("ovf_audio_hold", 64'(bus.AUDIO_OUT), 64'h11112222);
    send_word(1'b0, 16'h5555, 4, 32);
    send_word(1'b1, 16'h6666, 0, 32);
    lead();
    settle();
    chk("ovf_count", 64'(wr_cnt - base), 64'd2);
    pop_chk("ovf_f1", 32'h11112222);
    pop_chk("ovf_f3", 32'h55556666);
    chk("ovf_sticky", 64'(bus.OVERFLOW), 64'd1);
    bus.CLEAR_OVF = 1'b1;
    @(negedge mclk);
    bus.CLEAR_OVF = 1'b0;
    @(negedge mclk);
    chk("ovf_cleared", 64'(bus.OVERFLOW), 64'd0);
    #2;

    // SCLK stall mid-left-word.
    base = wr_cnt;
    send_word(1'b0, 16'hBEEF, 1, 12);
    repeat (50) @(negedge mclk);
    chk("stall_no_write", 64'(wr_cnt - base), 64'd0);
    send_word(1'b0, 16'hBEEF, 12, 32);
    send_word(1'b1, 16'hCAFE, 0, 32);
    lead();
    settle();
    chk("stall_count", 64'(wr_cnt - base), 64'd1);
    pop_chk("stall_data", 32'hBEEFCAFE);

    // Random data with varying SCLK rate and phase.
    base = wr_cnt;
    for (int f = 0; f < 20; f++) begin
      half_ns = 20 + int'($urandom_range(0, 7));
      rl = DB'($urandom);
      rr = DB'($urandom);
      exp_q.push_back({rl, rr});
      body(rl, rr, 32);
      lead();
    end
    half_ns = 20;
    settle();
    chk("rand_count", 64'(wr_cnt - base), 64'd20);
    while (exp_q.size() > 0) pop_chk("rand_data", exp_q.pop_front());

    chk("stray_audio_change", 64'(stray), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
